// File: rtl/mem_access_stage.sv
// MEM-stage controller: issues LW/SW to a variable-latency data memory over req/ack.
// Latency: non-memory instructions pass in 0 extra cycles; a memory op holds MEM for 2+N cycles (N = ACCESS cycles).
// Backpressure: while an access is outstanding, mem_stall freezes upstream and MEM/WB receives bubbles.
//
// Ports:
//   clk, rst                        - pipeline clock, synchronous active-high reset
//   MEM_valid/MemRead/MemWrite      - EX/MEM instruction qualifiers (both flags set => read)
//   MEM_ALU_result, MEM_wr_data     - effective address and store data
//   dmem_req/we/addr/wdata          - registered request to data memory, stable while req=1
//   dmem_ack, dmem_rdata            - completion strobe; rdata valid with ack on reads
//   MEM_data_mem_out                - captured load data presented to MEM/WB
//   mem_stall, MEM_WB_en, MEM_WB_flush - pipeline control, combinational from state and mop
//   mem_err                         - sticky access-timeout error
//
// Optional feature macro: MEM_TIMEOUT_EN (abort an access after TIMEOUT cycles without ack).
// Without it, ACCESS waits indefinitely and mem_err is tied to 0.

module mem_access_stage #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_valid,
   input  logic              MEM_MemRead,
   input  logic              MEM_MemWrite,
   input  logic [ADDR_W-1:0] MEM_ALU_result,
   input  logic [DATA_W-1:0] MEM_wr_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [DATA_W-1:0] MEM_data_mem_out,
   output logic              mem_stall,
   output logic              MEM_WB_en,
   output logic              MEM_WB_flush,
   output logic              mem_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                dmem_req_q, dmem_req_d;
   logic                dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                mop;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = 4;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
`endif

   assign mop = MEM_valid & (MEM_MemRead | MEM_MemWrite);

   always_comb begin
      state_d      = state_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      data_out_d   = data_out_q;
      mem_stall    = 1'b0;
      MEM_WB_en    = 1'b1;
      MEM_WB_flush = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = err_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (mop) begin
               mem_stall    = 1'b1;
               MEM_WB_en    = 1'b0;
               MEM_WB_flush = 1'b1;
               dmem_addr_d  = MEM_ALU_result;
               dmem_wdata_d = MEM_wr_data;
               // A malformed read+write encoding is issued as a read.
               dmem_we_d    = MEM_MemWrite & ~MEM_MemRead;
               dmem_req_d   = 1'b1;
               state_d      = ACCESS;
`ifdef MEM_TIMEOUT_EN
               cnt_d        = '0;
`endif
            end
         end

         ACCESS: begin
            mem_stall    = 1'b1;
            MEM_WB_en    = 1'b0;
            MEM_WB_flush = 1'b1;
            // Ack is checked first so a completion on the timeout cycle still counts.
            if (dmem_ack) begin
               if (!dmem_we_q) begin
                  data_out_d = dmem_rdata;
               end
               dmem_req_d = 1'b0;
               state_d    = DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // This is the TIMEOUT-th unanswered ACCESS cycle: abort the access.
               if (!dmem_we_q) begin
                  data_out_d = '0;
               end
               dmem_req_d = 1'b0;
               err_d      = 1'b1;
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end

         DONE: begin
            // The instruction retires into MEM/WB; a following memory op is picked up from IDLE.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         data_out_q   <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt_q        <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         data_out_q   <= data_out_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q        <= cnt_d;
         err_q        <= err_d;
`endif
      end
   end

   assign dmem_req         = dmem_req_q;
   assign dmem_we          = dmem_we_q;
   assign dmem_addr        = dmem_addr_q;
   assign dmem_wdata       = dmem_wdata_q;
   assign MEM_data_mem_out = data_out_q;

`ifdef MEM_TIMEOUT_EN
   assign mem_err = err_q;
`else
   assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues instructions and pushes the expected
// memory request and retirement record; a negedge monitor pops and compares as the DUT presents them.
// Inputs change #1 after posedge; outputs are sampled on negedge.

module tb_mem_access_stage;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int TIMEOUT = 15;

   logic              clk;
   logic              rst;
   logic              MEM_valid;
   logic              MEM_MemRead;
   logic              MEM_MemWrite;
   logic [ADDR_W-1:0] MEM_ALU_result;
   logic [DATA_W-1:0] MEM_wr_data;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [DATA_W-1:0] dmem_rdata;
   logic [DATA_W-1:0] MEM_data_mem_out;
   logic              mem_stall;
   logic              MEM_WB_en;
   logic              MEM_WB_flush;
   logic              mem_err;

   mem_access_stage #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .MEM_valid       (MEM_valid),
      .MEM_MemRead     (MEM_MemRead),
      .MEM_MemWrite    (MEM_MemWrite),
      .MEM_ALU_result  (MEM_ALU_result),
      .MEM_wr_data     (MEM_wr_data),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_ack        (dmem_ack),
      .dmem_rdata      (dmem_rdata),
      .MEM_data_mem_out(MEM_data_mem_out),
      .mem_stall       (mem_stall),
      .MEM_WB_en       (MEM_WB_en),
      .MEM_WB_flush    (MEM_WB_flush),
      .mem_err         (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit               we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                stalls;
      bit                err;
   } ret_t;

   req_t req_q[$];
   ret_t ret_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: what MEM_data_mem_out and mem_err must read after each instruction.
   logic [DATA_W-1:0] model_out = '0;
   bit                model_err = 1'b0;

   bit   mon_en    = 1'b0;
   bit   req_prev  = 1'b0;
   int   stall_cnt = 0;
   req_t cur_req;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: request rising edges pop the request queue, MEM/WB writes pop the retire queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (dmem_req && !req_prev) begin
            if (req_q.size() == 0) begin
               chk("unexpected_req", 32'd1, 32'd0);
            end else begin
               cur_req = req_q.pop_front();
               chk("req_we", 32'(dmem_we), 32'(cur_req.we));
               chk("req_addr", 32'(dmem_addr), 32'(cur_req.addr));
               chk("req_wdata", 32'(dmem_wdata), 32'(cur_req.wdata));
            end
         end else if (dmem_req) begin
            chk("hold_we", 32'(dmem_we), 32'(cur_req.we));
            chk("hold_addr", 32'(dmem_addr), 32'(cur_req.addr));
            chk("hold_wdata", 32'(dmem_wdata), 32'(cur_req.wdata));
         end
         req_prev = dmem_req;

         if (MEM_WB_en) begin
            chk("stall_on_retire", 32'(mem_stall), 32'd0);
            chk("flush_on_retire", 32'(MEM_WB_flush), 32'd0);
            if (ret_q.size() == 0) begin
               chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
               ret_t r;
               r = ret_q.pop_front();
               chk("data_out", 32'(MEM_data_mem_out), 32'(r.data));
               chk("stall_cycles", 32'(stall_cnt), 32'(r.stalls));
               chk("mem_err", 32'(mem_err), 32'(r.err));
            end
            stall_cnt = 0;
         end else begin
            chk("stall_while_held", 32'(mem_stall), 32'd1);
            chk("flush_while_held", 32'(MEM_WB_flush), 32'd1);
            stall_cnt++;
         end
      end
   end

   // Presents one instruction (called #1 after a posedge) and plays the memory side.
   // d = ACCESS cycle carrying the ack (1 = first); d = 0 means the memory never answers.
   task automatic issue(input bit v, input bit rd, input bit wr,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input int d, input logic [DATA_W-1:0] rdv);
      bit mop;
      bit is_rd;
      int n_access;
      ret_t r;
      mop   = v & (rd | wr);
      is_rd = rd;
      MEM_valid      = v;
      MEM_MemRead    = rd;
      MEM_MemWrite   = wr;
      MEM_ALU_result = a;
      MEM_wr_data    = wd;
      // Ack outside ACCESS must have no effect.
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = DATA_W'($urandom);
      if (!mop) begin
         r.data = model_out; r.stalls = 0; r.err = model_err;
         ret_q.push_back(r);
         @(posedge clk); #1;
         return;
      end
      req_q.push_back('{we: (wr && !rd), addr: a, wdata: wd});
      if (d == 0) begin
         n_access = TIMEOUT;
         if (is_rd) model_out = '0;
         model_err = 1'b1;
      end else begin
         n_access = d;
         if (is_rd) model_out = rdv;
      end
      r.data = model_out; r.stalls = 1 + n_access; r.err = model_err;
      ret_q.push_back(r);
      @(posedge clk); #1;
      for (int k = 1; k <= n_access; k++) begin
         dmem_ack   = (d != 0) && (k == d);
         dmem_rdata = (dmem_ack) ? rdv : DATA_W'($urandom);
         @(posedge clk); #1;
      end
      // DONE cycle: a stray ack here is a late ack and must be ignored.
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = DATA_W'($urandom);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      MEM_valid = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
      MEM_ALU_result = '0; MEM_wr_data = '0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk("rst_addr", 32'(dmem_addr), 32'd0);
      chk("rst_wdata", 32'(dmem_wdata), 32'd0);
      chk("rst_data_out", 32'(MEM_data_mem_out), 32'd0);
      chk("rst_err", 32'(mem_err), 32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      chk("rst_en", 32'(MEM_WB_en), 32'd1);

      // Reset in the 2nd ACCESS cycle of an LW, then a late ack.
      @(posedge clk); #1;
      MEM_valid = 1'b1; MEM_MemRead = 1'b1; MEM_ALU_result = 16'h0077;
      @(posedge clk); #1;            // ACCESS cycle 1
      @(posedge clk); #1 rst = 1'b1; // ACCESS cycle 2
      @(negedge clk);
      chk("midrst_req_before", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0; MEM_valid = 1'b0; MEM_MemRead = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = 16'hAAAA;
      @(negedge clk);
      chk("midrst_req", 32'(dmem_req), 32'd0);
      chk("midrst_stall", 32'(mem_stall), 32'd0);
      chk("midrst_data_out", 32'(MEM_data_mem_out), 32'd0);
      @(posedge clk); #1 dmem_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_req", 32'(dmem_req), 32'd0);
      chk("late_ack_data_out", 32'(MEM_data_mem_out), 32'd0);
      chk("late_ack_en", 32'(MEM_WB_en), 32'd1);

      @(posedge clk); #1;
      mon_en = 1'b1; req_prev = 1'b0; stall_cnt = 0;

      // Directed cases.
      issue(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);   // ADD
      issue(1, 1, 0, 16'h0040, 16'h0000, 1, 16'hBEEF);   // LW, ack on first ACCESS cycle
      issue(1, 0, 1, 16'h0010, 16'h1234, 4, 16'h5555);   // SW, ack after 4 cycles
      issue(1, 1, 0, 16'h0042, 16'h0000, 2, 16'hC0DE);   // LW then SW back-to-back
      issue(1, 0, 1, 16'h0044, 16'h9876, 1, 16'h0000);
      issue(1, 1, 1, 16'h0046, 16'h1111, 3, 16'h4242);   // both flags: treated as read
      issue(0, 1, 0, 16'h0048, 16'h2222, 1, 16'h3333);   // bubble with stale LW flag
      issue(1, 1, 0, 16'h004A, 16'h0000, TIMEOUT, 16'h7E57); // ack on the last allowed cycle

      // Randomized mix.
      for (int i = 0; i < 200; i++) begin
         int  kind;
         bit  v, rd, wr;
         kind = $urandom_range(0, 3);
         v  = (kind != 0);
         rd = (kind == 2) || (kind == 0 && $urandom_range(0, 1) == 1);
         wr = (kind == 3) || (kind == 2 && $urandom_range(0, 7) == 0);
         issue(v, rd, wr, ADDR_W'($urandom), DATA_W'($urandom),
               $urandom_range(1, 6), DATA_W'($urandom));
      end

`ifdef MEM_TIMEOUT_EN
      // Unanswered LW aborts; error stays set through later instructions.
      issue(1, 1, 0, 16'h0100, 16'h0000, 0, 16'h0000);
      issue(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
      issue(1, 1, 0, 16'h0102, 16'h0000, 2, 16'hFACE);
      issue(1, 0, 1, 16'h0104, 16'hABCD, 0, 16'h0000);
`endif

      mon_en = 1'b0;
      MEM_valid = 1'b0;
      @(posedge clk); #1;
      chk("req_queue_drained", 32'(req_q.size()), 32'd0);
      chk("retire_queue_drained", 32'(ret_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
